// File: rtl/qcs_pkg.sv
// Shared types and width helpers for the QC scheduler dispatch slice.
// Contents: opcode enum, dispatch state enum, width functions derived from
// the FPGA/qubit counts, and the instruction-word layout for the default
// 64 x 64 configuration.
package qcs_pkg;

  localparam int unsigned NUM_FPGA_DEF           = 64;
  localparam int unsigned NUM_QUBIT_PER_FPGA_DEF = 64;

  function automatic int unsigned fpga_w(input int unsigned num_fpga);
    return (num_fpga > 1) ? $clog2(num_fpga) : 1;
  endfunction

  function automatic int unsigned qubit_w(input int unsigned num_qubit);
    return (num_qubit > 1) ? $clog2(num_qubit) : 1;
  endfunction

  function automatic int unsigned opnd_w(input int unsigned num_fpga,
                                         input int unsigned num_qubit);
    return ((num_fpga * num_qubit) > 1) ? $clog2(num_fpga * num_qubit) : 1;
  endfunction

  function automatic int unsigned word_w(input int unsigned num_fpga,
                                         input int unsigned num_qubit);
    return 3 * opnd_w(num_fpga, num_qubit) + 20;
  endfunction

  localparam int unsigned OW_DEF = opnd_w(NUM_FPGA_DEF, NUM_QUBIT_PER_FPGA_DEF);

  typedef enum logic [1:0] {
    OP_NOP  = 2'b00,
    OP_1Q   = 2'b01,
    OP_2Q   = 2'b10,
    OP_MEAS = 2'b11
  } qcs_op_e;

  typedef enum logic [1:0] {
    StIdle   = 2'b00,
    StWait   = 2'b01,
    StLookup = 2'b10,
    StIssue  = 2'b11
  } qcs_state_e;

  // Instruction-word layout, MSB first, for the default configuration.
  typedef struct packed {
    logic [15:0]        start_time;
    qcs_op_e            op_code;
    logic [OW_DEF-1:0]  op_1;
    logic [OW_DEF-1:0]  op_2;
    logic [OW_DEF-1:0]  dest;
    logic [1:0]         status;
  } qcs_instr_t;

  // Serial-number comparison: start_time is due when it lies at most 2^15-1
  // ticks in the past of (or equal to) the current schedule time.
  function automatic logic is_due(input logic [15:0] now, input logic [15:0] start);
    logic [15:0] diff;
    diff = now - start;
    return ~diff[15];
  endfunction

endpackage

// File: rtl/qc_operand_map.sv
// Logical-operand to physical-location table.
// Ports:
//   clk, rst_n               clock, asynchronous active-low reset (clears valid bits)
//   we/waddr/wfpga/wqubit/wvld  single write port, takes effect on the clock edge
//   rd_en                    capture both read ports on this edge
//   raddr_a/raddr_b          read addresses
//   hit_a/hit_b              valid bit of the addressed entry, current contents
//   rd_fpga_*/rd_qubit_*     registered read data captured when rd_en
module qc_operand_map
  import qcs_pkg::*;
#(
  parameter int unsigned NUM_ENTRY = 4096,
  parameter int unsigned FW        = 6,
  parameter int unsigned QBW       = 6,
  localparam int unsigned AW       = (NUM_ENTRY > 1) ? $clog2(NUM_ENTRY) : 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           we,
  input  logic [AW-1:0]  waddr,
  input  logic [FW-1:0]  wfpga,
  input  logic [QBW-1:0] wqubit,
  input  logic           wvld,
  input  logic           rd_en,
  input  logic [AW-1:0]  raddr_a,
  input  logic [AW-1:0]  raddr_b,
  output logic           hit_a,
  output logic           hit_b,
  output logic [FW-1:0]  rd_fpga_a,
  output logic [QBW-1:0] rd_qubit_a,
  output logic [FW-1:0]  rd_fpga_b,
  output logic [QBW-1:0] rd_qubit_b
);

  logic [NUM_ENTRY-1:0] vld_q;
  logic [FW+QBW-1:0]    loc_q [NUM_ENTRY];

  // Only the valid bits are reset; location data is don't-care while invalid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
    end else if (we) begin
      vld_q[waddr] <= wvld;
    end
  end

  always_ff @(posedge clk) begin
    if (we) begin
      loc_q[waddr] <= {wfpga, wqubit};
    end
  end

  // Reads see the pre-write contents when a write lands on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_fpga_a  <= '0;
      rd_qubit_a <= '0;
      rd_fpga_b  <= '0;
      rd_qubit_b <= '0;
    end else if (rd_en) begin
      {rd_fpga_a, rd_qubit_a} <= loc_q[raddr_a];
      {rd_fpga_b, rd_qubit_b} <= loc_q[raddr_b];
    end
  end

  assign hit_a = vld_q[raddr_a];
  assign hit_b = vld_q[raddr_b];

endmodule

// File: rtl/qc_dispatch.sv
// Instruction dispatcher: pops one word from the decode queue, waits for its
// start_time, resolves operands through qc_operand_map and issues one gate.
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   in_word/in_valid/in_ready   queue pop interface
//   time_en/time_now       schedule time advance and current value
//   map_*                  operand-map write port
//   issue_*                gate issue handshake and fields
//   err_unmapped           one-cycle pulse when an instruction is dropped
//   busy                   dispatcher holds an instruction
// Optional: define QCS_DISPATCH_STATS_EN to add stat_issued/stat_remote/stat_err
// wrapping event counters.
module qc_dispatch
  import qcs_pkg::*;
#(
  parameter int unsigned NUM_FPGA           = 64,
  parameter int unsigned NUM_QUBIT_PER_FPGA = 64,
  localparam int unsigned FW           = fpga_w(NUM_FPGA),
  localparam int unsigned QBW          = qubit_w(NUM_QUBIT_PER_FPGA),
  localparam int unsigned NUM_OPERANDS = NUM_FPGA * NUM_QUBIT_PER_FPGA,
  localparam int unsigned OW           = opnd_w(NUM_FPGA, NUM_QUBIT_PER_FPGA),
  localparam int unsigned IW           = word_w(NUM_FPGA, NUM_QUBIT_PER_FPGA)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [IW-1:0]  in_word,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic           time_en,
  output logic [15:0]    time_now,
  input  logic           map_we,
  input  logic [OW-1:0]  map_addr,
  input  logic [FW-1:0]  map_fpga,
  input  logic [QBW-1:0] map_qubit,
  input  logic           map_vld,
  output logic           issue_valid,
  input  logic           issue_ready,
  output logic [1:0]     issue_op,
  output logic [FW-1:0]  issue_fpga_a,
  output logic [QBW-1:0] issue_qubit_a,
  output logic [FW-1:0]  issue_fpga_b,
  output logic [QBW-1:0] issue_qubit_b,
  output logic [OW-1:0]  issue_dest,
  output logic           issue_remote,
  output logic           err_unmapped,
  output logic           busy
`ifdef QCS_DISPATCH_STATS_EN
  ,
  output logic [15:0]    stat_issued,
  output logic [15:0]    stat_remote,
  output logic [15:0]    stat_err
`endif
);

  qcs_state_e     state_q, state_d;
  logic [15:0]    time_q;
  logic           out_of_rst_q;
  logic           err_q, err_d;
  logic [15:0]    start_q;
  qcs_op_e        op_q;
  logic [OW-1:0]  op1_q, op2_q, dest_q;
  logic           accept;
  logic           map_rd_en;
  logic           hit_a, hit_b;
  logic [FW-1:0]  rd_fpga_a, rd_fpga_b;
  logic [QBW-1:0] rd_qubit_a, rd_qubit_b;
  logic           is_2q;
  logic [1:0]     unused_status;

  assign unused_status = in_word[1:0];
  assign accept        = in_valid & in_ready;
  assign is_2q         = (op_q == OP_2Q);

  // Held instruction is cleared by reset so nothing survives into the next run.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      time_q       <= '0;
      out_of_rst_q <= 1'b0;
      err_q        <= 1'b0;
      start_q      <= '0;
      op_q         <= OP_NOP;
      op1_q        <= '0;
      op2_q        <= '0;
      dest_q       <= '0;
    end else begin
      state_q      <= state_d;
      out_of_rst_q <= 1'b1;
      err_q        <= err_d;
      if (time_en) begin
        time_q <= time_q + 16'd1;
      end
      if (accept) begin
        start_q <= in_word[IW-1 -: 16];
        op_q    <= qcs_op_e'(in_word[3*OW+3 -: 2]);
        op1_q   <= in_word[3*OW+1 -: OW];
        op2_q   <= in_word[2*OW+1 -: OW];
        dest_q  <= in_word[OW+1 -: OW];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    err_d     = 1'b0;
    map_rd_en = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (accept) state_d = StWait;
      end
      StWait: begin
        if (is_due(time_q, start_q)) begin
          state_d = (op_q == OP_NOP) ? StIdle : StLookup;
        end
      end
      StLookup: begin
        map_rd_en = 1'b1;
        // op_1 is required by every non-NOP op; op_2 only by two-qubit gates.
        if (!hit_a || (is_2q && !hit_b)) begin
          state_d = StIdle;
          err_d   = 1'b1;
        end else begin
          state_d = StIssue;
        end
      end
      StIssue: begin
        if (issue_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  qc_operand_map #(
    .NUM_ENTRY (NUM_OPERANDS),
    .FW        (FW),
    .QBW       (QBW)
  ) u_map (
    .clk        (clk),
    .rst_n      (rst_n),
    .we         (map_we),
    .waddr      (map_addr),
    .wfpga      (map_fpga),
    .wqubit     (map_qubit),
    .wvld       (map_vld),
    .rd_en      (map_rd_en),
    .raddr_a    (op1_q),
    .raddr_b    (op2_q),
    .hit_a      (hit_a),
    .hit_b      (hit_b),
    .rd_fpga_a  (rd_fpga_a),
    .rd_qubit_a (rd_qubit_a),
    .rd_fpga_b  (rd_fpga_b),
    .rd_qubit_b (rd_qubit_b)
  );

  // Issue fields are forced to zero outside ISSUE so idle outputs stay quiet.
  always_comb begin
    in_ready      = out_of_rst_q && (state_q == StIdle);
    busy          = (state_q != StIdle);
    time_now      = time_q;
    err_unmapped  = err_q;
    issue_valid   = (state_q == StIssue);
    issue_op      = 2'b00;
    issue_fpga_a  = '0;
    issue_qubit_a = '0;
    issue_fpga_b  = '0;
    issue_qubit_b = '0;
    issue_dest    = '0;
    issue_remote  = 1'b0;
    if (issue_valid) begin
      issue_op      = op_q;
      issue_fpga_a  = rd_fpga_a;
      issue_qubit_a = rd_qubit_a;
      issue_dest    = dest_q;
      if (is_2q) begin
        issue_fpga_b  = rd_fpga_b;
        issue_qubit_b = rd_qubit_b;
        issue_remote  = (rd_fpga_a != rd_fpga_b);
      end
    end
  end

`ifdef QCS_DISPATCH_STATS_EN
  logic [15:0] stat_issued_q, stat_remote_q, stat_err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_issued_q <= '0;
      stat_remote_q <= '0;
      stat_err_q    <= '0;
    end else begin
      if (issue_valid && issue_ready) begin
        stat_issued_q <= stat_issued_q + 16'd1;
        if (issue_remote) stat_remote_q <= stat_remote_q + 16'd1;
      end
      if (err_q) stat_err_q <= stat_err_q + 16'd1;
    end
  end

  assign stat_issued = stat_issued_q;
  assign stat_remote = stat_remote_q;
  assign stat_err    = stat_err_q;
`endif

endmodule

// File: tb/tb_qc_dispatch.sv
// Randomized self-checking bench for qc_dispatch with a transaction-level model.
module tb_qc_dispatch;
  import qcs_pkg::*;

  localparam int unsigned FW   = 6;
  localparam int unsigned QBW  = 6;
  localparam int unsigned OW   = 12;
  localparam int unsigned IW   = 56;
  localparam int unsigned NOPS = 4096;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [IW-1:0]  in_word = '0;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic           time_en = 1'b0;
  logic [15:0]    time_now;
  logic           map_we = 1'b0;
  logic [OW-1:0]  map_addr = '0;
  logic [FW-1:0]  map_fpga = '0;
  logic [QBW-1:0] map_qubit = '0;
  logic           map_vld = 1'b0;
  logic           issue_valid;
  logic           issue_ready = 1'b0;
  logic [1:0]     issue_op;
  logic [FW-1:0]  issue_fpga_a, issue_fpga_b;
  logic [QBW-1:0] issue_qubit_a, issue_qubit_b;
  logic [OW-1:0]  issue_dest;
  logic           issue_remote;
  logic           err_unmapped;
  logic           busy;
`ifdef QCS_DISPATCH_STATS_EN
  logic [15:0]    stat_issued, stat_remote, stat_err;
`endif

  qc_dispatch dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_word       (in_word),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .time_en       (time_en),
    .time_now      (time_now),
    .map_we        (map_we),
    .map_addr      (map_addr),
    .map_fpga      (map_fpga),
    .map_qubit     (map_qubit),
    .map_vld       (map_vld),
    .issue_valid   (issue_valid),
    .issue_ready   (issue_ready),
    .issue_op      (issue_op),
    .issue_fpga_a  (issue_fpga_a),
    .issue_qubit_a (issue_qubit_a),
    .issue_fpga_b  (issue_fpga_b),
    .issue_qubit_b (issue_qubit_b),
    .issue_dest    (issue_dest),
    .issue_remote  (issue_remote),
    .err_unmapped  (err_unmapped),
    .busy          (busy)
`ifdef QCS_DISPATCH_STATS_EN
    ,
    .stat_issued   (stat_issued),
    .stat_remote   (stat_remote),
    .stat_err      (stat_err)
`endif
  );

  always #5 clk = ~clk;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  bit          rand_ten = 1'b0;

  // Reference state: schedule time, operand map, event counts.
  logic [15:0]    m_time;
  bit             m_vld [NOPS];
  logic [FW-1:0]  m_f   [NOPS];
  logic [QBW-1:0] m_q   [NOPS];
  int unsigned    m_issued = 0, m_remote = 0, m_errs = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)       m_time <= 16'd0;
    else if (time_en) m_time <= m_time + 16'd1;
  end

  logic [38:0] got_iss;
  assign got_iss = {issue_op, issue_fpga_a, issue_qubit_a, issue_fpga_b, issue_qubit_b,
                    issue_dest, issue_remote};

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit due(input logic [15:0] t, input logic [15:0] s);
    int d;
    d = (int'(t) - int'(s) + 65536) % 65536;
    return d < 32768;
  endfunction

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    if (rand_ten) time_en = ($urandom_range(0, 3) != 0);
  endtask

  task automatic map_write(input logic [OW-1:0] a, input logic [FW-1:0] f,
                           input logic [QBW-1:0] q, input bit v);
    map_we = 1'b1; map_addr = a; map_fpga = f; map_qubit = q; map_vld = v;
    step();
    map_we = 1'b0;
    m_vld[a] = v; m_f[a] = f; m_q[a] = q;
  endtask

  task automatic run_instr(input logic [1:0] op, input logic [OW-1:0] o1,
                           input logic [OW-1:0] o2, input logic [OW-1:0] dst,
                           input logic [15:0] start, input int stall);
    qcs_instr_t     w;
    int             c;
    bit             found, ok, early;
    logic [FW-1:0]  fa, fb;
    logic [QBW-1:0] qa, qb;
    logic [38:0]    exp_iss;
    c = 0;
    while (!in_ready && c < 50) begin step(); c++; end
    check("ready_before_pop", 64'(in_ready), 64'(1));
    w.start_time = start; w.op_code = qcs_op_e'(op); w.op_1 = o1; w.op_2 = o2;
    w.dest = dst; w.status = 2'($urandom_range(0, 3));
    in_word = w; in_valid = 1'b1;
    step();
    in_valid = 1'b0; in_word = '0;
    // Outcome is fixed by the map contents seen at lookup; no writes occur meanwhile.
    ok = (op == 2'b00) || (m_vld[o1] && (op != 2'b10 || m_vld[o2]));
    fa = m_f[o1]; qa = m_q[o1];
    fb = (op == 2'b10) ? m_f[o2] : '0;
    qb = (op == 2'b10) ? m_q[o2] : '0;
    exp_iss = {op, fa, qa, fb, qb, dst, (op == 2'b10) && (fa != fb)};
    found = 1'b0; early = 1'b0; c = 0;
    while (!found && c < 3000) begin
      if (issue_valid || err_unmapped || !busy) early = 1'b1;
      if (due(m_time, start)) found = 1'b1;
      else begin step(); c++; end
    end
    check("held_until_due", 64'(early), 64'(0));
    check("due_reached", 64'(found), 64'(1));
    if (!found) return;
    if (op == 2'b00) begin
      step();
      check("nop_retire", 64'({busy, issue_valid, err_unmapped, in_ready}), 64'(4'b0001));
      return;
    end
    step();
    check("lookup", 64'({busy, issue_valid, err_unmapped, in_ready}), 64'(4'b1000));
    step();
    if (!ok) begin
      m_errs++;
      check("err_pulse", 64'({issue_valid, err_unmapped, in_ready, busy}), 64'(4'b0110));
      step();
      check("err_clear", 64'(err_unmapped), 64'(0));
      return;
    end
    check("issue_valid", 64'({issue_valid, in_ready}), 64'(2'b10));
    check("issue_fields", 64'(got_iss), 64'(exp_iss));
    check("issue_time", 64'(time_now), 64'(m_time));
    for (int s = 0; s < stall; s++) begin
      step();
      check("stall_hold", 64'({issue_valid, in_ready, got_iss}), 64'({2'b10, exp_iss}));
    end
    issue_ready = 1'b1;
    step();
    issue_ready = 1'b0;
    m_issued++;
    if (exp_iss[0]) m_remote++;
    check("post_transfer", 64'({issue_valid, busy, in_ready}), 64'(3'b001));
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]    op;
    logic [OW-1:0] o1, o2, dst;
    logic [15:0]   st;
    bit            seen;

    for (int i = 0; i < NOPS; i++) begin m_vld[i] = 1'b0; m_f[i] = '0; m_q[i] = '0; end

    // Reset state
    @(negedge clk);
    check("rst_outputs", 64'({in_ready, issue_valid, err_unmapped, busy, time_now, got_iss}),
          64'(0));
    step(); step();
    rst_n = 1'b1;
    time_en = 1'b1;
    step();
    check("ready_after_rst", 64'({in_ready, busy}), 64'(2'b10));

    // Same-FPGA two-qubit gate
    map_write(12'd5, 6'd3, 6'd7, 1'b1);
    map_write(12'd9, 6'd3, 6'd8, 1'b1);
    run_instr(2'b10, 12'd5, 12'd9, 12'd0, 16'd20, 0);
    // Cross-FPGA two-qubit gate
    map_write(12'd9, 6'd4, 6'd1, 1'b1);
    run_instr(2'b10, 12'd5, 12'd9, 12'd0, m_time + 16'd6, 0);
    // Unmapped operand
    run_instr(2'b01, 12'd33, 12'd0, 12'd0, m_time, 0);
    // Back-pressure for 10 cycles; measure with op_2 ignored
    run_instr(2'b11, 12'd5, 12'd9, 12'd77, m_time + 16'd2, 10);
    // Schedule-time wrap
    while (m_time != 16'd65530) step();
    run_instr(2'b01, 12'd5, 12'd9, 12'd1, 16'd3, 2);
    // Late instruction is due at once
    while (m_time != 16'd100) step();
    run_instr(2'b10, 12'd5, 12'd9, 12'd2, 16'd65000, 0);
    run_instr(2'b00, 12'd0, 12'd0, 12'd0, m_time + 16'd4, 0);

    // Randomized traffic
    rand_ten = 1'b1;
    repeat (60) begin
      if ($urandom_range(0, 1) == 1)
        map_write(OW'($urandom_range(0, 15)), FW'($urandom_range(0, 7)),
                  QBW'($urandom_range(0, 63)), $urandom_range(0, 3) != 0);
      op  = 2'($urandom_range(0, 3));
      o1  = OW'($urandom_range(0, 15));
      o2  = ($urandom_range(0, 7) == 0) ? OW'($urandom_range(16, NOPS - 1))
                                        : OW'($urandom_range(0, 15));
      dst = OW'($urandom_range(0, NOPS - 1));
      st  = ($urandom_range(0, 1) == 1) ? m_time + 16'($urandom_range(0, 40))
                                        : m_time - 16'($urandom_range(0, 500));
      run_instr(op, o1, o2, dst, st, int'($urandom_range(0, 4)));
    end
    rand_ten = 1'b0;
    time_en = 1'b1;

`ifdef QCS_DISPATCH_STATS_EN
    check("stat_issued", 64'(stat_issued), 64'(m_issued % 65536));
    check("stat_remote", 64'(stat_remote), 64'(m_remote % 65536));
    check("stat_err", 64'(stat_err), 64'(m_errs % 65536));
`endif

    // Reset while an instruction waits
    map_write(12'd5, 6'd3, 6'd7, 1'b1);
    st = m_time + 16'd1000;
    in_word = {st, 2'b01, 12'd5, 12'd0, 12'd0, 2'b00};
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step(); step();
    check("wait_busy", 64'(busy), 64'(1));
    rst_n = 1'b0;
    #1;
    check("rst_mid_outputs", 64'({in_ready, issue_valid, err_unmapped, busy, time_now, got_iss}),
          64'(0));
    for (int i = 0; i < NOPS; i++) m_vld[i] = 1'b0;
    m_issued = 0; m_remote = 0; m_errs = 0;
    step(); step();
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (30) begin
      step();
      if (issue_valid || busy || err_unmapped) seen = 1'b1;
    end
    check("no_ghost_issue", 64'(seen), 64'(0));
    // Map was cleared, so the same operand is now unmapped
    run_instr(2'b01, 12'd5, 12'd0, 12'd0, m_time, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
